// File: rtl/rgb_fader.sv
// rgb_fader: six-hue RGB wheel with PWM channels, hard step or crossfade.
// Drives active-low RGB/LED pins; heartbeat LED toggles on each hue advance.
module rgb_fader #(
  parameter int HOLD_CYCLES = 12000000,
  parameter int STEP_CYCLES = 47000,
  parameter int PWM_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic       LED,
  output logic [2:0] color_idx,
  output logic       advance
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  localparam int HW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW =
    (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [HW-1:0] HOLD_LAST =
    HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST =
    SW'(STEP_CYCLES - 1);

  typedef enum logic {
    S_HOLD = 1'b0,
    S_FADE = 1'b1
  } state_t;

  // Hue wheel: {R,G,B} lit flags for each index
  function automatic logic [2:0] f_hue(
    input logic [2:0] idx
  );
    logic [2:0] h;
    case (idx)
      3'd0:    h = 3'b100;
      3'd1:    h = 3'b110;
      3'd2:    h = 3'b010;
      3'd3:    h = 3'b011;
      3'd4:    h = 3'b001;
      3'd5:    h = 3'b101;
      default: h = 3'b100;
    endcase
    return h;
  endfunction

  function automatic logic [2:0] f_next(
    input logic [2:0] idx
  );
    return (idx == 3'd5) ? 3'd0 : idx + 3'd1;
  endfunction

  // One LSB toward the target, or hold if already there
  function automatic logic [PWM_BITS-1:0] f_step(
    input logic [PWM_BITS-1:0] cur,
    input logic [PWM_BITS-1:0] tgt
  );
    logic [PWM_BITS-1:0] n;
    if (cur < tgt)
      n = cur + 1'b1;
    else if (cur > tgt)
      n = cur - 1'b1;
    else
      n = cur;
    return n;
  endfunction

  state_t              r_state;
  logic [HW-1:0]       r_hold_cnt;
  logic [SW-1:0]       r_step_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_duty_r;
  logic [PWM_BITS-1:0] r_duty_g;
  logic [PWM_BITS-1:0] r_duty_b;
  logic [2:0]          r_color_idx;
  logic                r_advance;
  logic                r_led;
  logic                r_pin_r;
  logic                r_pin_g;
  logic                r_pin_b;

  logic [2:0]          w_hue;
  logic [2:0]          w_nidx;
  logic [2:0]          w_nhue;
  logic [PWM_BITS-1:0] w_tgt_r;
  logic [PWM_BITS-1:0] w_tgt_g;
  logic [PWM_BITS-1:0] w_tgt_b;
  logic [PWM_BITS-1:0] w_stp_r;
  logic [PWM_BITS-1:0] w_stp_g;
  logic [PWM_BITS-1:0] w_stp_b;
  logic                w_fade_done;
  logic                w_lit_r;
  logic                w_lit_g;
  logic                w_lit_b;

  // Current/next targets, fade step values and PWM compare
  always_comb begin
    w_hue   = f_hue(r_color_idx);
    w_nidx  = f_next(r_color_idx);
    w_nhue  = f_hue(w_nidx);
    w_tgt_r = {PWM_BITS{w_hue[2]}};
    w_tgt_g = {PWM_BITS{w_hue[1]}};
    w_tgt_b = {PWM_BITS{w_hue[0]}};
    w_stp_r = f_step(r_duty_r, w_tgt_r);
    w_stp_g = f_step(r_duty_g, w_tgt_g);
    w_stp_b = f_step(r_duty_b, w_tgt_b);
    w_fade_done = (w_stp_r == w_tgt_r) &&
                  (w_stp_g == w_tgt_g) &&
                  (w_stp_b == w_tgt_b);
    w_lit_r = (r_duty_r == MAX) ||
              (r_pwm_cnt < r_duty_r);
    w_lit_g = (r_duty_g == MAX) ||
              (r_pwm_cnt < r_duty_g);
    w_lit_b = (r_duty_b == MAX) ||
              (r_pwm_cnt < r_duty_b);
  end

  // Free-running PWM counter, independent of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pwm_cnt <= '0;
    else
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

  // Registered active-low pin drives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pin_r <= 1'b1;
      r_pin_g <= 1'b1;
      r_pin_b <= 1'b1;
    end else begin
      r_pin_r <= ~w_lit_r;
      r_pin_g <= ~w_lit_g;
      r_pin_b <= ~w_lit_b;
    end
  end

  // Hold/fade sequencer with hue, duty and heartbeat state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_HOLD;
      r_hold_cnt  <= '0;
      r_step_cnt  <= '0;
      r_duty_r    <= MAX;
      r_duty_g    <= '0;
      r_duty_b    <= '0;
      r_color_idx <= 3'd0;
      r_advance   <= 1'b0;
      r_led       <= 1'b1;
    end else begin
      r_advance <= 1'b0;
      if (en) begin
        case (r_state)
          S_HOLD: begin
            if (r_hold_cnt == HOLD_LAST) begin
              r_hold_cnt  <= '0;
              r_color_idx <= w_nidx;
              r_advance   <= 1'b1;
              r_led       <= ~r_led;
              if (mode) begin
                r_state    <= S_FADE;
                r_step_cnt <= '0;
              end else begin
                r_duty_r <= {PWM_BITS{w_nhue[2]}};
                r_duty_g <= {PWM_BITS{w_nhue[1]}};
                r_duty_b <= {PWM_BITS{w_nhue[0]}};
              end
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
          S_FADE: begin
            if (r_step_cnt == STEP_LAST) begin
              r_step_cnt <= '0;
              r_duty_r   <= w_stp_r;
              r_duty_g   <= w_stp_g;
              r_duty_b   <= w_stp_b;
              if (w_fade_done) begin
                r_state    <= S_HOLD;
                r_hold_cnt <= '0;
              end
            end else begin
              r_step_cnt <= r_step_cnt + 1'b1;
            end
          end
          default: r_state <= S_HOLD;
        endcase
      end
    end
  end

  assign RGB_R     = r_pin_r;
  assign RGB_G     = r_pin_g;
  assign RGB_B     = r_pin_b;
  assign LED       = r_led;
  assign color_idx = r_color_idx;
  assign advance   = r_advance;

endmodule

// File: doc/rgb_fader.md
Name: rgb_fader

Overview:
Parametrised successor to the on-board RGB colour cycler. It steps through the same six-hue wheel: red, yellow, green, cyan, blue, purple, then wraps. Each channel is driven by an 8-bit-class PWM instead of plain on/off. A mode input selects a hard step or a linear crossfade between adjacent hues. The block sits directly on the iceBlinkPico RGB and LED pins; all pin outputs are active low.

Parameters:
HOLD_CYCLES, 12000000, clk cycles the block dwells at each full hue (1 s at 12 MHz); must be >= 1.
STEP_CYCLES, 47000, clk cycles per 1-LSB duty step during a crossfade (about 1 s fade at PWM_BITS=8); must be >= 1.
PWM_BITS, 8, PWM counter and duty width; MAX = 2^PWM_BITS-1.

Ports:
clk  input  1  12 MHz system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  1 = run; 0 = freeze hold, step and colour state while PWM keeps running.
mode  input  1  0 = hard step, 1 = crossfade; sampled only at the end of a hold.
RGB_R, RGB_G, RGB_B  output  1 each  PWM pin drives, active low (0 = lit).
LED  output  1  heartbeat, active low; toggles on every hue advance.
color_idx  output  3  current or target hue index, 0..5.
advance  output  1  single-cycle pulse on each hue advance.

Behaviour:
- Reset (async assert, released synchronously):
  - RGB_R = RGB_G = RGB_B = 1; LED = 1; advance = 0; color_idx = 0.
  - State HOLD; hold_cnt = 0; step_cnt = 0; pwm_cnt = 0.
  - Duties duty_r/duty_g/duty_b = MAX/0/0 (red).
- Hue targets (R,G,B), where each component is 0 or MAX:
  - idx 0 = (MAX,0,0); 1 = (MAX,MAX,0); 2 = (0,MAX,0).
  - idx 3 = (0,MAX,MAX); 4 = (0,0,MAX); 5 = (MAX,0,MAX).
  - Adjacent hues differ in exactly one channel.
- PWM:
  - pwm_cnt runs free (PWM_BITS wide, wraps MAX->0) regardless of en.
  - Channel lit when duty == MAX, or when pwm_cnt < duty. duty == 0 means never lit.
  - Pin outputs are registered: a pin reflects the previous cycle's compare (1-cycle latency).
- HOLD state:
  - While en, hold_cnt increments each cycle.
  - When hold_cnt == HOLD_CYCLES-1 and en:
    - hold_cnt <= 0; color_idx <= (idx == 5) ? 0 : idx+1.
    - advance <= 1 for one cycle; LED toggles.
    - mode == 0: all duties load the new target on the same edge; stay in HOLD.
    - mode == 1: go to FADE with step_cnt = 0; duties are unchanged at this edge.
- FADE state:
  - While en, step_cnt increments.
  - When step_cnt == STEP_CYCLES-1: step_cnt <= 0, and each duty moves 1 toward its target (+1 or -1; unchanged if equal).
  - When the step makes all duties equal their targets: go to HOLD with hold_cnt = 0 on that edge.
  - A full fade therefore lasts MAX*STEP_CYCLES cycles.
- Mode change mid-fade is ignored; the fade completes. The new mode applies at the next advance.
- en = 0 freezes hold_cnt, step_cnt, duties, color_idx and state; advance stays 0.
- Asserting rst mid-fade or mid-hold returns everything to the reset values immediately.
- Counter widths: $clog2 of the respective limit; no overflow past the limit is permitted.

Test Plan:
- Parameters HOLD_CYCLES=10, STEP_CYCLES=2, PWM_BITS=3, mode=0, en=1, release rst -> RGB_R=0 continuously, RGB_G=RGB_B=1; advance pulses on cycles 10, 20, 30…; color_idx runs 1,2,3,4,5,0; LED toggles at each pulse.
- Same parameters, mode=1, first advance -> duty_g steps 0->7 by +1 every 2 cycles (14 cycles); RGB_G low-time per 8-cycle PWM period grows 0,1..6, then fully low; HOLD then lasts 10 cycles before the next advance.
- Crossfade from idx 1 to 2 -> duty_r ramps 7->0; RGB_R pin is fully high once duty_r = 0; duty_g stays 7.
- Hold en=0 for 25 cycles mid-fade -> duties, step_cnt and color_idx are unchanged and there is no advance pulse; PWM pins keep toggling at the frozen duty; resuming finishes the fade with correct timing.
- Switch mode 1->0 mid-fade -> the fade completes; the next advance is a hard step with duties loaded on the advance edge.
- Assert rst for 1 cycle during the idx 4 fade -> pins go 1/1/1 immediately; afterwards color_idx=0 and red is lit from cycle 1.
